// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: MIPS opcode/funct constants and the
// hazard/stall FSM state encoding, imported by the hazard stall unit
// and its operand-use decoder.
package pipeline_pkg;

  // Primary opcodes (instruction bits [31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_SB    = 6'h28;
  localparam logic [5:0] OP_SH    = 6'h29;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type function codes (instruction bits [5:0])
  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_SRA = 6'h03;
  localparam logic [5:0] FN_JR  = 6'h08;

  typedef enum logic {
    HZ_IDLE  = 1'b0,
    HZ_STALL = 1'b1
  } hz_state_t;

  // True when a used source register equals a producer's destination.
  // Register 0 is hard-wired to zero, so it never creates a dependency.
  function automatic logic src_match(input logic       uses,
                                     input logic [4:0] src,
                                     input logic [4:0] dst);
    return uses && (src == dst) && (dst != 5'd0);
  endfunction

endpackage

// File: rtl/operand_use_decoder.sv
// Decodes which source operands (rs, rt) the ID-stage instruction reads.
// Ports: ID_Instruction in; usesRs/usesRt flags and Rs/Rt fields out.
// Purely combinational, no clock or reset.
module operand_use_decoder
  import pipeline_pkg::*;
(
  input  logic [31:0] ID_Instruction,
  output logic        usesRs,
  output logic        usesRt,
  output logic [4:0]  Rs,
  output logic [4:0]  Rt
);

  logic [5:0] w_op;
  logic [5:0] w_fn;
  logic       w_unused;

  assign w_op     = ID_Instruction[31:26];
  assign w_fn     = ID_Instruction[5:0];
  assign Rs       = ID_Instruction[25:21];
  assign Rt       = ID_Instruction[20:16];
  // rd/shamt/immediate bits play no part in operand use
  assign w_unused = ^ID_Instruction[15:6];

  always_comb begin
    usesRs = 1'b0;
    usesRt = 1'b0;
    case (w_op)
      OP_RTYPE: begin
        // Shifts by immediate take their operand from rt only; jr is an
        // R-type reading rs (its rt field is zero, so usesRt is harmless).
        usesRs = !((w_fn == FN_SLL) || (w_fn == FN_SRL) || (w_fn == FN_SRA));
        usesRt = 1'b1;
      end
      OP_J, OP_JAL, OP_LUI: begin
        usesRs = 1'b0;
        usesRt = 1'b0;
      end
      OP_BEQ, OP_BNE, OP_SB, OP_SH, OP_SW: begin
        usesRs = 1'b1;
        usesRt = 1'b1;
      end
      default: begin
        // Remaining I-type: rs is a source, rt is the destination
        usesRs = 1'b1;
        usesRt = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/hazard_stall_unit.sv
// Stall/flush controller for the 5-stage MIPS pipeline: detects load-use
// and ID-stage branch operand hazards, holds PC/IF-ID, bubbles ID/EX and
// flushes IF/ID on taken branches. First stall cycle is combinational;
// the second cycle of a two-cycle stall comes from the registered FSM.
// Ports: Clock/Reset (async active-high); ID instruction + branch info;
// EX/MEM producer info; PCWrite, IFIDWrite, IDEXBubble, IFIDFlush out.
// Optional macro HAZARD_STALL_COUNT_EN adds the StallCount output: a
// saturating count of bubble cycles since reset.
module hazard_stall_unit
  import pipeline_pkg::*;
(
  input  logic        Clock,
  input  logic        Reset,
  input  logic [31:0] ID_Instruction,
  input  logic        ID_Branch,
  input  logic        BranchTaken,
  input  logic        EX_MemRead,
  input  logic        EX_RegWrite,
  input  logic [4:0]  EX_WriteReg,
  input  logic        MEM_MemRead,
  input  logic [4:0]  MEM_WriteReg,
  output logic        PCWrite,
  output logic        IFIDWrite,
  output logic        IDEXBubble,
  output logic        IFIDFlush
`ifdef HAZARD_STALL_COUNT_EN
  ,
  output logic [31:0] StallCount
`endif
);

  logic       w_uses_rs;
  logic       w_uses_rt;
  logic [4:0] w_rs;
  logic [4:0] w_rt;

  operand_use_decoder u_decode (
    .ID_Instruction (ID_Instruction),
    .usesRs         (w_uses_rs),
    .usesRt         (w_uses_rt),
    .Rs             (w_rs),
    .Rt             (w_rt)
  );

  // ---------------------------------------------------------------------
  // Hazard classification
  // ---------------------------------------------------------------------
  logic w_match_ex;
  logic w_match_mem;
  logic w_load_use;
  logic w_br_alu;
  logic w_br_load_ex;
  logic w_br_load_mem;
  logic w_hazard;
  logic w_need_two;

  assign w_match_ex  = src_match(w_uses_rs, w_rs, EX_WriteReg) ||
                       src_match(w_uses_rt, w_rt, EX_WriteReg);
  assign w_match_mem = src_match(w_uses_rs, w_rs, MEM_WriteReg) ||
                       src_match(w_uses_rt, w_rt, MEM_WriteReg);

  assign w_load_use    = EX_MemRead && w_match_ex;
  assign w_br_alu      = ID_Branch && EX_RegWrite && !EX_MemRead && w_match_ex;
  assign w_br_load_ex  = ID_Branch && EX_MemRead && w_match_ex;
  assign w_br_load_mem = ID_Branch && MEM_MemRead && w_match_mem;

  // Every class needs at least one cycle; only a branch waiting on a load
  // still in EX needs two (load data is not ready for ID until after MEM).
  assign w_hazard   = w_load_use || w_br_alu || w_br_load_ex || w_br_load_mem;
  assign w_need_two = w_br_load_ex;

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  hz_state_t r_state;
  hz_state_t w_state_nxt;
  logic      r_remaining;
  logic      w_remaining_nxt;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_state     <= HZ_IDLE;
      r_remaining <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_remaining <= w_remaining_nxt;
    end
  end

  // ---------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    w_state_nxt     = r_state;
    w_remaining_nxt = r_remaining;
    case (r_state)
      HZ_IDLE: begin
        // The first stall cycle is taken here combinationally; STALL
        // covers only the cycles beyond it.
        if (w_need_two) begin
          w_state_nxt     = HZ_STALL;
          w_remaining_nxt = 1'b1;
        end
      end
      HZ_STALL: begin
        w_remaining_nxt = (r_remaining != 1'b0) ? r_remaining - 1'b1 : 1'b0;
        if (w_remaining_nxt == 1'b0) begin
          w_state_nxt = HZ_IDLE;
        end
      end
      default: begin
        w_state_nxt     = HZ_IDLE;
        w_remaining_nxt = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------
  logic w_stall;

  always_comb begin
    // Reset masks the combinational hazard path so every output shows its
    // reset value while Reset is high, even with a hazard on the inputs.
    w_stall    = !Reset && ((r_state == HZ_STALL) ||
                            ((r_state == HZ_IDLE) && w_hazard));
    PCWrite    = !w_stall;
    IFIDWrite  = !w_stall;
    IDEXBubble = w_stall;
    // A taken branch with pending operands was resolved on stale data
    IFIDFlush  = !Reset && BranchTaken && !w_stall;
  end

`ifdef HAZARD_STALL_COUNT_EN
  logic [31:0] r_stall_count;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_stall_count <= 32'd0;
    end else if (IDEXBubble && (r_stall_count != 32'hFFFF_FFFF)) begin
      r_stall_count <= r_stall_count + 32'd1;
    end
  end

  assign StallCount = r_stall_count;
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed-vector bench for hazard_stall_unit with a scoreboard queue:
// the driver pushes hand-computed expectations, a negedge monitor pops
// and compares. Build with or without HAZARD_STALL_COUNT_EN.
module tb_hazard_stall_unit;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic [31:0] ID_Instruction = 32'd0;
  logic        ID_Branch = 1'b0;
  logic        BranchTaken = 1'b0;
  logic        EX_MemRead = 1'b0;
  logic        EX_RegWrite = 1'b0;
  logic [4:0]  EX_WriteReg = 5'd0;
  logic        MEM_MemRead = 1'b0;
  logic [4:0]  MEM_WriteReg = 5'd0;
  logic        PCWrite;
  logic        IFIDWrite;
  logic        IDEXBubble;
  logic        IFIDFlush;
`ifdef HAZARD_STALL_COUNT_EN
  logic [31:0] StallCount;
`endif

  hazard_stall_unit dut (
    .Clock          (Clock),
    .Reset          (Reset),
    .ID_Instruction (ID_Instruction),
    .ID_Branch      (ID_Branch),
    .BranchTaken    (BranchTaken),
    .EX_MemRead     (EX_MemRead),
    .EX_RegWrite    (EX_RegWrite),
    .EX_WriteReg    (EX_WriteReg),
    .MEM_MemRead    (MEM_MemRead),
    .MEM_WriteReg   (MEM_WriteReg),
    .PCWrite        (PCWrite),
    .IFIDWrite      (IFIDWrite),
    .IDEXBubble     (IDEXBubble),
    .IFIDFlush      (IFIDFlush)
`ifdef HAZARD_STALL_COUNT_EN
    ,
    .StallCount     (StallCount)
`endif
  );

  always #5 Clock = ~Clock;

  // {PCWrite, IFIDWrite, IDEXBubble, IFIDFlush}
  localparam logic [3:0] NORM = 4'b1100;
  localparam logic [3:0] STL  = 4'b0010;
  localparam logic [3:0] FLSH = 4'b1101;

  typedef struct {
    logic [3:0]  ctl;
    logic [31:0] cnt;
    string       name;
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_cnt = 32'd0;

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  // Drive one cycle of inputs just after the rising edge and queue the
  // expected outputs for that cycle.
  task automatic vec(input string name, input logic [31:0] instr,
                     input logic br, input logic tk,
                     input logic exmr, input logic exrw, input logic [4:0] exwr,
                     input logic memmr, input logic [4:0] memwr,
                     input logic rst, input logic [3:0] ctl);
    exp_t e;
    @(posedge Clock);
    #1;
    Reset          = rst;
    ID_Instruction = instr;
    ID_Branch      = br;
    BranchTaken    = tk;
    EX_MemRead     = exmr;
    EX_RegWrite    = exrw;
    EX_WriteReg    = exwr;
    MEM_MemRead    = memmr;
    MEM_WriteReg   = memwr;
    if (rst) exp_cnt = 32'd0;
    e.ctl  = ctl;
    e.cnt  = exp_cnt;
    e.name = name;
    // Counter is registered: this cycle's bubble shows up next cycle
    if (ctl[1] && !rst && exp_cnt != 32'hFFFF_FFFF) exp_cnt = exp_cnt + 32'd1;
    sb_q.push_back(e);
  endtask

  // Monitor: outputs are presented every cycle; compare at the falling edge
  initial begin
    exp_t e;
    forever begin
      @(negedge Clock);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        checks++;
        if ({PCWrite, IFIDWrite, IDEXBubble, IFIDFlush} !== e.ctl) begin
          errors++;
          $display("FAIL %s ctl got=%b exp=%b (PCWrite,IFIDWrite,IDEXBubble,IFIDFlush)",
                   e.name, {PCWrite, IFIDWrite, IDEXBubble, IFIDFlush}, e.ctl);
        end
`ifdef HAZARD_STALL_COUNT_EN
        checks++;
        if (StallCount !== e.cnt) begin
          errors++;
          $display("FAIL %s StallCount got=%0d exp=%0d", e.name, StallCount, e.cnt);
        end
`endif
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "simulation did not complete");
  end

  initial begin
    logic [31:0] i_nop, i_add, i_beq, i_bne6, i_bne0, i_lui, i_j, i_addi;
    logic [31:0] i_sll, i_sw, i_jr, i_fwd;
    i_nop  = 32'd0;
    i_add  = rtype(5'd8, 5'd11, 5'd10, 6'h20);         // add $10,$8,$11
    i_beq  = itype(6'h04, 5'd4, 5'd5, 16'h0010);       // beq $4,$5
    i_bne6 = itype(6'h05, 5'd6, 5'd0, 16'h0010);       // bne $6,$0
    i_bne0 = itype(6'h05, 5'd0, 5'd0, 16'h0010);       // bne $0,$0
    i_lui  = itype(6'h0F, 5'd7, 5'd7, 16'h1234);       // lui $7 (rs field 7)
    i_j    = {6'h02, 5'd7, 5'd7, 16'h0040};            // j, fields look like $7
    i_addi = itype(6'h08, 5'd2, 5'd7, 16'h0005);       // addi $7,$2,5
    i_sll  = rtype(5'd7, 5'd1, 5'd2, 6'h00);           // sll $2,$1 with rs=7
    i_sw   = itype(6'h2B, 5'd2, 5'd7, 16'h0000);       // sw $7,0($2)
    i_jr   = rtype(5'd7, 5'd0, 5'd0, 6'h08);           // jr $7
    i_fwd  = rtype(5'd6, 5'd1, 5'd10, 6'h20);          // add $10,$6,$1

    //   name        instr   br tk  exmr exrw exwr   memmr memwr  rst  exp
    vec("reset",     i_nop,  0, 0,  0,   0,   5'd0,  0,    5'd0,  1,   NORM);
    vec("release",   i_nop,  0, 0,  0,   0,   5'd0,  0,    5'd0,  0,   NORM);
    // load-use: exactly one stall
    vec("lu_stall",  i_add,  0, 0,  1,   1,   5'd8,  0,    5'd0,  0,   STL);
    vec("lu_after",  i_add,  0, 0,  0,   0,   5'd0,  1,    5'd8,  0,   NORM);
    // branch after load: two stalls (second from FSM), flush only after
    vec("bl_s1",     i_beq,  1, 1,  1,   1,   5'd4,  0,    5'd0,  0,   STL);
    vec("bl_s2",     i_beq,  1, 1,  0,   0,   5'd0,  0,    5'd0,  0,   STL);
    vec("bl_flush",  i_beq,  1, 1,  0,   0,   5'd0,  0,    5'd0,  0,   FLSH);
    vec("cnt3",      i_nop,  0, 0,  0,   0,   5'd0,  0,    5'd0,  0,   NORM);
    // branch after ALU
    vec("ba_stall",  i_bne6, 1, 0,  0,   1,   5'd6,  0,    5'd0,  0,   STL);
    vec("ba_done",   i_bne6, 1, 0,  0,   0,   5'd0,  0,    5'd0,  0,   NORM);
    vec("ba_zero",   i_bne0, 1, 0,  0,   1,   5'd0,  0,    5'd0,  0,   NORM);
    vec("alu_fwd",   i_fwd,  0, 0,  0,   1,   5'd6,  0,    5'd0,  0,   NORM);
    // non-use of the loaded register
    vec("nu_lui",    i_lui,  0, 0,  1,   1,   5'd7,  0,    5'd0,  0,   NORM);
    vec("nu_j",      i_j,    0, 0,  1,   1,   5'd7,  0,    5'd0,  0,   NORM);
    vec("nu_addi",   i_addi, 0, 0,  1,   1,   5'd7,  0,    5'd0,  0,   NORM);
    vec("nu_sll",    i_sll,  0, 0,  1,   1,   5'd7,  0,    5'd0,  0,   NORM);
    // store reads rt
    vec("st_sw",     i_sw,   0, 0,  1,   1,   5'd7,  0,    5'd0,  0,   STL);
    vec("st_after",  i_sw,   0, 0,  0,   0,   5'd0,  1,    5'd7,  0,   NORM);
    // branch on a load in MEM: one stall
    vec("bm_stall",  i_beq,  1, 0,  0,   0,   5'd0,  1,    5'd5,  0,   STL);
    vec("bm_done",   i_beq,  1, 0,  0,   0,   5'd0,  0,    5'd0,  0,   NORM);
    // jr on a load in EX: two stalls, then taken flush
    vec("jr_s1",     i_jr,   1, 0,  1,   1,   5'd7,  0,    5'd0,  0,   STL);
    vec("jr_s2",     i_jr,   1, 0,  0,   0,   5'd0,  0,    5'd0,  0,   STL);
    vec("jr_flush",  i_jr,   1, 1,  0,   0,   5'd0,  0,    5'd0,  0,   FLSH);
    vec("flush_free",i_beq,  1, 1,  0,   0,   5'd0,  0,    5'd0,  0,   FLSH);
    // reset in the second stall cycle, then re-evaluation afterwards
    vec("rs_s1",     i_beq,  1, 0,  1,   1,   5'd4,  0,    5'd0,  0,   STL);
    vec("rs_rst",    i_nop,  0, 0,  0,   0,   5'd0,  0,    5'd0,  1,   NORM);
    vec("rs_rel",    i_nop,  0, 0,  0,   0,   5'd0,  0,    5'd0,  0,   NORM);
    vec("rs_re1",    i_beq,  1, 0,  1,   1,   5'd4,  0,    5'd0,  0,   STL);
    vec("rs_re2",    i_nop,  0, 0,  0,   0,   5'd0,  0,    5'd0,  0,   STL);
    vec("rs_end",    i_nop,  0, 0,  0,   0,   5'd0,  0,    5'd0,  0,   NORM);

    for (int k = 0; k < 10 && sb_q.size() > 0; k++) @(negedge Clock);
    #1;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain %0d expectations left, need 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_stall_unit.md
# hazard_stall_unit

Stall and flush controller for the five-stage MIPS pipeline; the producer-side counterpart to the EX-stage forwarding mux control. It detects the RAW hazards that forwarding cannot resolve: load-use into EX, and branch/jr operands consumed in ID. For those hazards it holds PC and IF/ID, injects bubbles into ID/EX, and flushes IF/ID on taken branches. A small state machine enforces multi-cycle stalls, so a stall sequence never depends on re-evaluating a held instruction.

## Interface
Parameters:
- none (widths fixed by the ISA)

Ports:
- Clock  in  1  pipeline clock; all state updates on the rising edge
- Reset  in  1  asynchronous, active-high; forces IDLE, clears counters
- ID_Instruction  in  32  instruction currently in IF/ID
- ID_Branch  in  1  the ID instruction is beq/bne/jr and is resolved in ID
- BranchTaken  in  1  the ID-stage branch/jr resolves taken this cycle
- EX_MemRead  in  1  the ID/EX instruction is a load
- EX_RegWrite  in  1  the ID/EX instruction writes a register
- EX_WriteReg  in  5  destination register of the ID/EX instruction
- MEM_MemRead  in  1  the EX/MEM instruction is a load
- MEM_WriteReg  in  5  destination register of the EX/MEM instruction
- PCWrite  out  1  PC update enable (0 = hold)
- IFIDWrite  out  1  IF/ID load enable (0 = hold)
- IDEXBubble  out  1  zero all ID/EX control fields this cycle
- IFIDFlush  out  1  replace IF/ID contents with a nop on the next edge
- StallCount  out  32  total stall cycles since reset (present only with HAZARD_STALL_COUNT_EN)

## Operation
- Operand use: decoded from ID_Instruction[31:26]/[5:0].
  - usesRs: R-type (except sll/srl/sra), all I-type except lui, and jr.
  - usesRt: R-type, stores (sb/sh/sw), beq, bne.
  - j, jal, lui use neither operand.
  - A match against register 0 never counts.
- Hazard classes, evaluated in IDLE only. N is the total number of stall cycles.
  - Load-use: EX_MemRead and EX_WriteReg matches a used source. N=1.
  - Branch-ALU: ID_Branch, EX_RegWrite, not EX_MemRead, and EX_WriteReg matches a used source. N=1.
  - Branch-load-EX: ID_Branch, EX_MemRead, and a match. N=2. This takes priority over load-use.
  - Branch-load-MEM: ID_Branch, MEM_MemRead, and MEM_WriteReg matches a used source. N=1.
  - If several classes apply, the maximum N is taken.
- FSM states: IDLE, STALL.
  - IDLE, hazard with N≥1: assert stall this cycle (combinational). If N=2, go to STALL with remaining=1. Otherwise stay in IDLE.
  - STALL: assert stall unconditionally and decrement remaining. At remaining=0, return to IDLE and re-evaluate on the following cycle.
  - 1-bit remaining counter.
- Stall outputs: PCWrite=0, IFIDWrite=0, IDEXBubble=1.
- Flush: IFIDFlush = BranchTaken AND not stalling. A taken branch is never flushed while its operands are pending.
- Reset mid-STALL: immediately returns to IDLE; the held instruction is re-evaluated after Reset is released.

## Timing
- Reset values: state=IDLE, PCWrite=1, IFIDWrite=1, IDEXBubble=0, IFIDFlush=0, StallCount=0.
- First stall cycle: zero latency, combinational from inputs in IDLE.
- Second stall cycle (N=2): comes from registered state; it does not depend on the inputs.
- No bubble is ever inserted without PC/IF/ID also being held in the same cycle.

## Configuration
- HAZARD_STALL_COUNT_EN defined:
  - StallCount port and register exist.
  - Increments by 1 every cycle in which IDEXBubble=1.
  - Saturates at 32'hFFFFFFFF.
- HAZARD_STALL_COUNT_EN undefined: no port and no register. All other behaviour is identical.

## Structure
- Shared package `pipeline_pkg` holds:
  - opcode constants: OP_RTYPE, OP_BEQ, OP_BNE, OP_J, OP_JAL, OP_LUI, OP_SB, OP_SH, OP_SW
  - funct constants: FN_SLL, FN_SRL, FN_SRA, FN_JR
  - FSM state encoding: HZ_IDLE, HZ_STALL
- Sub-module `operand_use_decoder`: ID_Instruction in; usesRs, usesRt, Rs, Rt out. Pure combinational.

## Test plan
- Load-use: lw $8,0($9) in EX, add $10,$8,$11 in ID → exactly 1 cycle of PCWrite=0/IFIDWrite=0/IDEXBubble=1, then normal flow.
- Branch after load: lw $4 in EX, beq $4,$5 in ID → 2 consecutive stall cycles, then BranchTaken=1 gives IFIDFlush=1 on the third cycle only.
- Branch after ALU: add $6 in EX, bne $6,$0 in ID → 1 stall cycle. Same case with $0 as destination → no stall.
- Non-use: lw $7 in EX, lui $7 / j target in ID → no stall. lw $7 in EX, addi $3,$2,$7-field in rt → no stall.
- Reset mid-STALL: assert Reset in the second branch-load stall cycle → outputs immediately return to reset values, state=IDLE.
- HAZARD_STALL_COUNT_EN: run the load-use case followed by the branch-load case → StallCount=3.
